pkt_fifo: RTL and testbench

PKT_FIFO -- requirements
Module: pkt_fifo

---
 rtl/pkt_fifo.sv | 103 ++++++++++
 tb/tb_pkt_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pkt_fifo.sv
// Single-clock first-word-fall-through packet FIFO with sticky overflow/underflow flags.
// Optional macro PKT_FIFO_DROP_CNT_EN adds a saturating 16-bit dropped-write counter (drop_cnt).
module pkt_fifo #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 64,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_to_fifo,
  input  logic [DATA_W-1:0]        fifo_in,
  output logic                     almost_full,
  output logic                     full,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     flush,
  output logic                     overflow,
  output logic                     underflow,
`ifdef PKT_FIFO_DROP_CNT_EN
  output logic [15:0]              drop_cnt,
`endif
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
    logic ovf;
    logic udf;
  } evt_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  evt_t              evt;

  // flush swallows any concurrent request, so it can never raise a flag
  always_comb begin
    evt        = '0;
    evt.wr_acc = wr_to_fifo & ~flush & ~full;
    evt.rd_acc = rd_en & ~flush & ~empty;
    evt.ovf    = wr_to_fifo & ~flush & full;
    evt.udf    = rd_en & ~flush & empty;
  end

  assign empty       = (level == '0);
  assign full        = (level == LW'(DEPTH));
  assign almost_full = (level >= LW'(AFULL_THRESH));
  assign rd_data     = mem[rd_ptr];

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (evt.wr_acc) mem[wr_ptr] <= fifo_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (evt.wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (evt.rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({evt.wr_acc, evt.rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A new error in the clearing cycle wins over clr_flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_flags) | evt.ovf;
      underflow <= (underflow & ~clr_flags) | evt.udf;
    end
  end

`ifdef PKT_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (clr_flags) begin
      drop_cnt <= evt.ovf ? 16'd1 : 16'd0;
    end else if (evt.ovf && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed self-checking bench for pkt_fifo at DEPTH=8, AFULL_THRESH=6.
module tb_pkt_fifo;
  localparam int DW = 32;
  localparam int D  = 8;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_to_fifo, rd_en, flush, clr_flags;
  logic [DW-1:0] fifo_in;
  logic          almost_full, full, empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [3:0]    level;
`ifdef PKT_FIFO_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pkt_fifo #(.DATA_W(DW), .DEPTH(D), .AFULL_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .wr_to_fifo(wr_to_fifo), .fifo_in(fifo_in),
    .almost_full(almost_full), .full(full), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .level(level), .flush(flush), .overflow(overflow),
    .underflow(underflow),
`ifdef PKT_FIFO_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then idle the inputs
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic f, input logic c);
    wr_to_fifo = w; fifo_in = d; rd_en = r; flush = f; clr_flags = c;
    @(posedge clk); #1;
    wr_to_fifo = 0; fifo_in = '0; rd_en = 0; flush = 0; clr_flags = 0;
  endtask

  task automatic test_reset;
    reset = 0; wr_to_fifo = 0; fifo_in = '0; rd_en = 0; flush = 0; clr_flags = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", almost_full); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=%b%b exp=00", overflow, underflow); end
`ifdef PKT_FIFO_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_dropcnt got=%0d exp=0", drop_cnt); end
`endif
    reset = 1;
  endtask

  task automatic test_almost_full;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 32'h11 + i, 0, 0, 0);
      total++; if (level !== 4'(i + 1)) begin bad++; $display("FAIL afull_level%0d got=%0d exp=%0d", i, level, i + 1); end
      if (i == 4) begin
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL afull_below got=%b exp=0", almost_full); end
      end
    end
    total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL afull_at got=%b exp=1", almost_full); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL afull_full got=%b exp=0", full); end
    total++; if (rd_data !== 32'h11) begin bad++; $display("FAIL afull_head got=%h exp=11", rd_data); end
  endtask

  task automatic test_overflow;
    cyc(1, 32'h17, 0, 0, 0);
    cyc(1, 32'h18, 0, 0, 0);
    total++; if (full !== 1'b1 || level !== 4'd8) begin
      bad++; $display("FAIL ovf_fill got full=%b level=%0d exp full=1 level=8", full, level); end
    cyc(1, 32'hDEAD, 1, 0, 0);
    total++; if (level !== 4'd7) begin bad++; $display("FAIL ovf_level got=%0d exp=7", level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    total++; if (underflow !== 1'b0 || full !== 1'b0) begin
      bad++; $display("FAIL ovf_other got udf=%b full=%b exp 0 0", underflow, full); end
`ifdef PKT_FIFO_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_dropcnt got=%0d exp=1", drop_cnt); end
`endif
    for (int i = 0; i < 7; i++) begin
      total++; if (rd_data !== 32'h12 + i) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, rd_data, 32'h12 + i); end
      cyc(0, '0, 1, 0, 0);
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b exp=1", empty); end
  endtask

  task automatic test_underflow;
    cyc(0, '0, 0, 0, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b exp=0", overflow); end
    cyc(1, 32'hA5, 1, 0, 0);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", underflow); end
    total++; if (level !== 4'd1) begin bad++; $display("FAIL udf_level got=%0d exp=1", level); end
    total++; if (rd_data !== 32'hA5) begin bad++; $display("FAIL udf_data got=%h exp=a5", rd_data); end
`ifdef PKT_FIFO_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL udf_dropcnt got=%0d exp=0", drop_cnt); end
`endif
    cyc(0, '0, 1, 0, 0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL udf_pop got=%b exp=1", empty); end
  endtask

  task automatic test_stream;
    cyc(0, '0, 0, 0, 1);
    cyc(1, 32'd0, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      total++; if (rd_data !== 32'(i - 1)) begin bad++; $display("FAIL stream_data%0d got=%0d exp=%0d", i, rd_data, i - 1); end
      cyc(1, 32'(i), 1, 0, 0);
      total++; if (level !== 4'd1) begin bad++; $display("FAIL stream_level%0d got=%0d exp=1", i, level); end
    end
    total++; if (rd_data !== 32'd19) begin bad++; $display("FAIL stream_last got=%0d exp=19", rd_data); end
    cyc(0, '0, 1, 0, 0);
    total++; if (empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL stream_end got empty=%b ovf=%b udf=%b exp 1 0 0", empty, overflow, underflow); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) cyc(1, 32'h30 + i, 0, 0, 0);
    total++; if (level !== 4'd5) begin bad++; $display("FAIL flush_pre got=%0d exp=5", level); end
    cyc(1, 32'h77, 1, 1, 0);
    total++; if (level !== 4'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL flush_level got level=%0d empty=%b exp 0 1", level, empty); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      bad++; $display("FAIL flush_noflag got=%b%b exp=00", overflow, underflow); end
    cyc(1, 32'h5A, 0, 0, 0);
    total++; if (rd_data !== 32'h5A || level !== 4'd1) begin
      bad++; $display("FAIL flush_after got data=%h level=%0d exp 5a 1", rd_data, level); end
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL flush_keep got=%b exp=1", underflow); end
    for (int i = 0; i < 8; i++) cyc(1, 32'h40 + i, 0, 0, 0);
    cyc(1, 32'hBAD, 0, 0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_pre got=%b exp=1", overflow); end
    cyc(1, 32'hBEEF, 0, 0, 1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clr_coincide got=%b exp=1", overflow); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL clr_udf got=%b exp=0", underflow); end
`ifdef PKT_FIFO_DROP_CNT_EN
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL clr_dropcnt got=%0d exp=1", drop_cnt); end
`endif
    cyc(0, '0, 0, 0, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_only got=%b exp=0", overflow); end
    total++; if (rd_data !== 32'h40 || level !== 4'd8) begin
      bad++; $display("FAIL clr_contents got data=%h level=%0d exp 40 8", rd_data, level); end
  endtask

  task automatic test_reset_mid;
    #2 reset = 0;
    #1;
    total++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
      bad++; $display("FAIL rstmid got level=%0d empty=%b full=%b exp 0 1 0", level, empty, full); end
    @(negedge clk);
    reset = 1;
    cyc(1, 32'h99, 0, 0, 0);
    total++; if (level !== 4'd1 || rd_data !== 32'h99) begin
      bad++; $display("FAIL rstmid_first got level=%0d data=%h exp 1 99", level, rd_data); end
  endtask

  initial begin
    test_reset;
    test_almost_full;
    test_overflow;
    test_underflow;
    test_stream;
    test_flush;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
